n15_qspi_xip_arbiter: RTL and testbench

//  Shares the single QSPI flash port between two read requesters: port 0 for CPU instruction fetch
//  and port 1 for data and TDI debug reads. It arbitrates round-robin and sequences one quad-I/O

---
 rtl/n15_qspi_xip_arbiter.sv | 109 ++++++++++
 tb/tb_n15_qspi_xip_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/n15_qspi_xip_arbiter.sv
// n15_qspi_xip_arbiter: round-robin two-port arbiter sequencing one quad-I/O EBh flash read per grant
module n15_qspi_xip_arbiter #(
  parameter logic [7:0] RD_CMD      = 8'hEB,
  parameter int         DUMMY_SCK   = 4,
  parameter int         CS_HIGH_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [23:0] req0_addr,
  output logic        req0_ready,
  output logic        resp0_valid,
  input  logic        req1_valid,
  input  logic [23:0] req1_addr,
  output logic        req1_ready,
  output logic        resp1_valid,
  output logic [31:0] resp_data,
  output logic        busy,
  output logic        FSCK,
  output logic        FCEN,
  output logic [3:0]  FDO,
  output logic        FDOEN,
  input  logic [3:0]  FDI
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, GAP} state_t;
  state_t state, nstate;
  logic [3:0] cnt, ncnt, len;
  logic [15:0] gap;
  logic ph, last_grant, grant, gnt, acc, last_sck;
  logic [23:0] addr, ash;
  logic [27:0] sh;
  logic [31:0] full, word;
  logic [4:0] nxt_pins;
  always_comb begin
    grant = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    acc = state == IDLE && (req0_valid || req1_valid);
    req0_ready = acc && !grant;
    req1_ready = acc && grant;
    len = state == CMD ? 4'd8 : state == ADDR ? 4'd6 : state == MODE ? 4'd2 :
          state == DUMMY ? 4'(DUMMY_SCK) : 4'd8;
    last_sck = cnt == len - 4'd1;
    nstate = last_sck ? state_t'(state + 3'd1) : state;
    ncnt = last_sck ? 4'd0 : cnt + 4'd1;
    ash = addr >> {3'(3'd5 - ncnt[2:0]), 2'b00};
    nxt_pins = nstate == CMD  ? {4'b1111, RD_CMD[~ncnt[2:0]]} :
               nstate == ADDR ? {1'b1, ash[3:0]} :
               nstate == MODE ? 5'b10000 : 5'b01111;
    // first nibble received is the high nibble of the byte at the lowest address
    full = {sh, FDI};
    word = {full[7:0], full[15:8], full[23:16], full[31:24]};
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      gap <= '0;
      ph <= 1'b0;
      last_grant <= 1'b1;
      gnt <= 1'b0;
      addr <= '0;
      sh <= '0;
      resp_data <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      FCEN <= 1'b1;
      FSCK <= 1'b0;
      FDO <= 4'hF;
      FDOEN <= 1'b0;
    end else begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      if (state == IDLE) begin
        if (acc) begin
          state <= CMD;
          cnt <= '0;
          ph <= 1'b0;
          gnt <= grant;
          last_grant <= grant;
          addr <= {grant ? req1_addr[23:2] : req0_addr[23:2], 2'b00};
          FCEN <= 1'b0;
          {FDOEN, FDO} <= {4'b1111, RD_CMD[7]};
        end
      end else if (state == GAP) begin
        gap <= gap + 16'd1;
        if (gap == 16'(CS_HIGH_CYC - 1)) state <= IDLE;
      end else if (!ph) begin
        ph <= 1'b1;
        FSCK <= 1'b1;
      end else begin
        ph <= 1'b0;
        FSCK <= 1'b0;
        if (state == DATA) sh <= full[27:0];
        if (state == DATA && last_sck) begin
          state <= GAP;
          gap <= '0;
          FCEN <= 1'b1;
          {FDOEN, FDO} <= 5'b01111;
          resp_data <= word;
          resp0_valid <= !gnt;
          resp1_valid <= gnt;
        end else begin
          state <= nstate;
          cnt <= ncnt;
          {FDOEN, FDO} <= nxt_pins;
        end
      end
    end
endmodule

// File: tb/tb_n15_qspi_xip_arbiter.sv
// tb_n15_qspi_xip_arbiter: flash pin model plus arbitration/data reference checks
module tb_n15_qspi_xip_arbiter;
  localparam int CS = 4;
  localparam int LAT = 57;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0;
  logic [23:0] req0_addr = 0, req1_addr = 0;
  logic req0_ready, req1_ready, resp0_valid, resp1_valid, busy;
  logic [31:0] resp_data;
  logic FSCK, FCEN, FDOEN;
  logic [3:0] FDO, FDI = 0;
  int pass_n = 0, total_n = 0;
  int cyc = 0;
  bit model_last = 1;

  n15_qspi_xip_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready), .resp0_valid(resp0_valid),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready), .resp1_valid(resp1_valid),
    .resp_data(resp_data), .busy(busy),
    .FSCK(FSCK), .FCEN(FCEN), .FDO(FDO), .FDOEN(FDOEN), .FDI(FDI)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [7:0] mem [256];
  function automatic logic [31:0] exp_word(input logic [23:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
  endfunction

  // flash: counts SCK rising edges per chip-select window, captures command/address, drives data
  int k = 0, edges_last = 0, pin_err = 0, di;
  logic [7:0] cmd_cap, fb;
  logic [23:0] adr_cap;
  always @(negedge FCEN) begin k = 0; cmd_cap = 0; adr_cap = 0; end
  always @(posedge FCEN) edges_last = k;
  always @(posedge FSCK) begin
    if (k < 8) begin
      cmd_cap = {cmd_cap[6:0], FDO[0]};
      if (FDO[3:2] !== 2'b11) pin_err++;
    end else if (k < 14) adr_cap = {adr_cap[19:0], FDO};
    else if (k < 16) begin
      if (FDO !== 4'h0) pin_err++;
    end
    if (FDOEN !== (k < 16)) pin_err++;
    if (k >= 20 && k < 28) begin
      di = k - 20;
      fb = mem[8'(adr_cap[7:0] + 8'(di / 2))];
      FDI = (di % 2 == 0) ? fb[7:4] : fb[3:0];
    end
    k++;
  end

  typedef struct {int p; logic [31:0] d; int t;} resp_t;
  resp_t rq[$];
  int hi_run = 0, min_gap = 1000, lo_start = 0, lo_end = 0, both_rdy = 0;
  logic fcen_q = 1;
  always @(negedge clk) begin
    if (resp0_valid || resp1_valid) rq.push_back('{resp1_valid ? 1 : 0, resp_data, cyc});
    if (req0_ready && req1_ready) both_rdy++;
    if (FCEN) hi_run++;
    else begin
      if (hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
      hi_run = 0;
    end
    if (!FCEN && fcen_q) lo_start = cyc;
    if (FCEN && !fcen_q) lo_end = cyc - 1;
    fcen_q = FCEN;
  end

  task automatic issue(input int p, input logic [23:0] a, output int t0, output bit ok);
    ok = 0;
    t0 = 0;
    if (p == 0) begin req0_valid = 1; req0_addr = a; end
    else begin req1_valid = 1; req1_addr = a; end
    for (int i = 0; i < 300 && !ok; i++) begin
      #1;
      if ((p == 0) ? req0_ready : req1_ready) begin ok = 1; t0 = cyc; end
      @(negedge clk);
    end
    if (p == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic wait_rq(input int n);
    for (int i = 0; i < 400 && rq.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    total_n++; if (FCEN !== 1'b1) $display("FAIL reset_fcen got %b want 1", FCEN); else pass_n++;
    total_n++; if (FSCK !== 1'b0) $display("FAIL reset_fsck got %b want 0", FSCK); else pass_n++;
    total_n++; if (FDO !== 4'hF) $display("FAIL reset_fdo got %h want f", FDO); else pass_n++;
    total_n++; if (FDOEN !== 1'b0) $display("FAIL reset_fdoen got %b want 0", FDOEN); else pass_n++;
    total_n++; if (resp_data !== 32'h0) $display("FAIL reset_data got %h want 0", resp_data); else pass_n++;
    total_n++; if ({busy, req0_ready, req1_ready, resp0_valid, resp1_valid} !== 5'b0)
      $display("FAIL reset_ctl got %b want 00000", {busy, req0_ready, req1_ready, resp0_valid, resp1_valid}); else pass_n++;
  endtask

  task automatic test_tie;
    int ta, tb2;
    bit oka, okb;
    logic [23:0] a0, a1;
    resp_t r;
    int first, second;
    bit exp_p[$];
    logic [31:0] exp_d[$];
    rq.delete();
    min_gap = 1000;
    for (int round = 0; round < 2; round++) begin
      a0 = 24'($urandom);
      a1 = 24'($urandom);
      fork
        issue(0, a0, ta, oka);
        issue(1, a1, tb2, okb);
      join
      first = model_last ? 0 : 1;
      second = 1 - first;
      model_last = bit'(second);
      exp_p.push_back(bit'(first)); exp_d.push_back(first == 0 ? exp_word(a0) : exp_word(a1));
      exp_p.push_back(bit'(second)); exp_d.push_back(second == 0 ? exp_word(a0) : exp_word(a1));
      total_n++; if (!(oka && okb)) $display("FAIL tie_accept got %b%b want 11", oka, okb); else pass_n++;
      total_n++; if (((first == 0) ? tb2 - ta : ta - tb2) !== LAT + CS)
        $display("FAIL tie_spacing got %0d want %0d", (first == 0) ? tb2 - ta : ta - tb2, LAT + CS); else pass_n++;
    end
    wait_rq(4);
    total_n++; if (rq.size() !== 4) $display("FAIL tie_resp_count got %0d want 4", rq.size()); else pass_n++;
    for (int i = 0; i < 4 && i < rq.size(); i++) begin
      r = rq[i];
      total_n++; if (r.p !== int'(exp_p[i]) || r.d !== exp_d[i])
        $display("FAIL tie_resp%0d got p%0d %h want p%0d %h", i, r.p, r.d, exp_p[i], exp_d[i]); else pass_n++;
    end
    total_n++; if (min_gap < CS) $display("FAIL tie_cs_gap got %0d want >=%0d", min_gap, CS); else pass_n++;
  endtask

  task automatic test_single;
    int t0;
    bit ok;
    rq.delete();
    pin_err = 0;
    issue(0, 24'h000100, t0, ok);
    wait_rq(1);
    total_n++; if (!ok || rq.size() !== 1) $display("FAIL single_resp got ok=%0d n=%0d want 1 1", ok, rq.size()); else pass_n++;
    if (rq.size() > 0) begin
      total_n++; if (rq[0].p !== 0) $display("FAIL single_port got %0d want 0", rq[0].p); else pass_n++;
      total_n++; if (rq[0].t !== t0 + LAT) $display("FAIL single_lat got %0d want %0d", rq[0].t - t0, LAT); else pass_n++;
      total_n++; if (rq[0].d !== 32'h44332211) $display("FAIL single_data got %h want 44332211", rq[0].d); else pass_n++;
    end
    total_n++; if (cmd_cap !== 8'hEB) $display("FAIL single_cmd got %h want eb", cmd_cap); else pass_n++;
    total_n++; if (adr_cap !== 24'h000100) $display("FAIL single_addr got %h want 000100", adr_cap); else pass_n++;
    total_n++; if (edges_last !== 28) $display("FAIL single_edges got %0d want 28", edges_last); else pass_n++;
    total_n++; if (pin_err !== 0) $display("FAIL single_pins got %0d errors want 0", pin_err); else pass_n++;
    total_n++; if (lo_start !== t0 + 1 || lo_end !== t0 + 56)
      $display("FAIL single_fcen_window got %0d..%0d want 1..56", lo_start - t0, lo_end - t0); else pass_n++;
    repeat (CS) @(negedge clk);
  endtask

  task automatic test_unaligned;
    int t0;
    bit ok;
    rq.delete();
    issue(1, 24'h000103, t0, ok);
    model_last = 1;
    wait_rq(1);
    total_n++; if (!ok || rq.size() !== 1) $display("FAIL unal_resp got ok=%0d n=%0d want 1 1", ok, rq.size()); else pass_n++;
    if (rq.size() > 0) begin
      total_n++; if (rq[0].p !== 1 || rq[0].d !== 32'h44332211)
        $display("FAIL unal_data got p%0d %h want p1 44332211", rq[0].p, rq[0].d); else pass_n++;
    end
    total_n++; if (adr_cap !== 24'h000100) $display("FAIL unal_addr got %h want 000100", adr_cap); else pass_n++;
    repeat (CS) @(negedge clk);
  endtask

  task automatic test_random;
    int ta, tb2, first, second;
    bit oka, okb;
    logic [1:0] pat;
    logic [23:0] a0, a1;
    bit exp_p[$];
    logic [31:0] exp_d[$];
    rq.delete();
    both_rdy = 0;
    pin_err = 0;
    for (int it = 0; it < 8; it++) begin
      pat = 2'($urandom_range(1, 3));
      a0 = 24'($urandom);
      a1 = 24'($urandom);
      oka = 1; okb = 1; ta = 0; tb2 = 0;
      fork
        if (pat[0]) issue(0, a0, ta, oka);
        if (pat[1]) issue(1, a1, tb2, okb);
      join
      total_n++; if (!(oka && okb)) $display("FAIL rand_accept%0d got %b%b want 11", it, oka, okb); else pass_n++;
      first = (pat == 2'b11) ? (model_last ? 0 : 1) : (pat[0] ? 0 : 1);
      exp_p.push_back(bit'(first)); exp_d.push_back(first == 0 ? exp_word(a0) : exp_word(a1));
      model_last = bit'(first);
      if (pat == 2'b11) begin
        second = 1 - first;
        exp_p.push_back(bit'(second)); exp_d.push_back(second == 0 ? exp_word(a0) : exp_word(a1));
        model_last = bit'(second);
        total_n++; if (((first == 0) ? tb2 - ta : ta - tb2) < LAT + CS)
          $display("FAIL rand_order%0d got first=%0d t0=%0d t1=%0d", it, first, ta, tb2); else pass_n++;
      end
    end
    wait_rq(exp_p.size());
    total_n++; if (rq.size() !== exp_p.size()) $display("FAIL rand_count got %0d want %0d", rq.size(), exp_p.size()); else pass_n++;
    for (int i = 0; i < rq.size() && i < exp_p.size(); i++) begin
      total_n++; if (rq[i].p !== int'(exp_p[i]) || rq[i].d !== exp_d[i])
        $display("FAIL rand_resp%0d got p%0d %h want p%0d %h", i, rq[i].p, rq[i].d, exp_p[i], exp_d[i]); else pass_n++;
    end
    total_n++; if (both_rdy !== 0) $display("FAIL rand_onehot_ready got %0d want 0", both_rdy); else pass_n++;
    total_n++; if (pin_err !== 0) $display("FAIL rand_pins got %0d want 0", pin_err); else pass_n++;
    repeat (CS) @(negedge clk);
  endtask

  task automatic test_drop_reset;
    int t0;
    bit ok;
    logic [23:0] a;
    rq.delete();
    a = 24'($urandom);
    issue(0, a, t0, ok);
    total_n++; if (req0_valid !== 1'b0 || cyc !== t0 + 1) $display("FAIL drop_time got %0d want 1", cyc - t0); else pass_n++;
    wait_rq(1);
    model_last = 0;
    total_n++; if (rq.size() !== 1 || rq[0].t !== t0 + LAT || rq[0].d !== exp_word(a))
      $display("FAIL drop_resp got n=%0d want 1 at %0d data %h", rq.size(), LAT, exp_word(a)); else pass_n++;
    repeat (CS) @(negedge clk);
    rq.delete();
    issue(0, 24'($urandom), t0, ok);
    while (cyc < t0 + 30) @(negedge clk);
    rst = 1;
    #1;
    total_n++; if ({FCEN, FSCK, FDOEN, FDO, busy} !== 8'b10011110)
      $display("FAIL reset_mid got %b want 10011110", {FCEN, FSCK, FDOEN, FDO, busy}); else pass_n++;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    model_last = 1;
    repeat (80) @(negedge clk);
    total_n++; if (rq.size() !== 0) $display("FAIL reset_noresp got %0d want 0", rq.size()); else pass_n++;
    a = 24'($urandom);
    issue(1, a, t0, ok);
    wait_rq(1);
    total_n++; if (rq.size() !== 1 || rq[0].p !== 1 || rq[0].t !== t0 + LAT || rq[0].d !== exp_word(a))
      $display("FAIL reset_next got n=%0d want 1 p1 data %h", rq.size(), exp_word(a)); else pass_n++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 0;
    @(negedge clk);
    test_tie;
    test_single;
    test_unaligned;
    test_random;
    test_drop_reset;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
